// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package vic_pkg;

    // Request/acknowledge handshake states towards the CPU INT pin
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACKED = 2'd2
    } state_e;

    // Register window offsets
    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_ISR  = 2'd3;

    // The CPU adds the vector index to this base to find the ISR pointer
    localparam logic [11:0] VEC_TABLE_BASE = 12'h7F0;

    // Index 8 lands on table entry 0x7F8, reserved for the spurious handler
    localparam int DEF_SPURIOUS_VEC = 8;

    // Internal vectors are always padded to this width
    localparam int MAX_SRC = 8;

    // Index of the lowest set bit (0 when the vector is empty)
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // One-hot of the lowest set bit (0 when the vector is empty)
    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/vec_int_ctrl_irq_sync.sv
// Per-source input conditioning: multi-flop synchroniser followed by a
// rising-edge detector on the synchronised level.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic level_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw request through the synchroniser and remember the last level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign edge_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: conditions up to 8 requests, prioritises
// them against MASK and the in-service set, drives the CPU INT pin and
// returns the vector index during the one-cycle intack window.
module vec_int_ctrl
    import vic_pkg::*;
#(
    parameter int N_SRC        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int SPURIOUS_VEC = DEF_SPURIOUS_VEC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq,
    input  logic             reg_sel,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [15:0]      reg_wdata,
    output logic [15:0]      reg_rdata,
    output logic             intr,
    input  logic             intack,
    output logic [15:0]      vec_out
);

    // Bits that correspond to real sources; everything above reads 0
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

    logic [7:0] level_w;
    logic [7:0] rise_w;

    // Registered state
    logic [7:0] mask_q, mask_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] isr_q,  isr_d;
    state_e     state_q;
    logic       intr_q;

    // Priority resolution
    logic [7:0] pending_w;
    logic [7:0] cand_w;
    logic [2:0] winner_w;
    logic [2:0] isr_low_w;
    logic [7:0] win_oh_w;
    logic       eligible_w;
    logic       ack_hit_w;
    logic       wr_w;
    logic       unused_w;

    // One conditioning chain per implemented source, constant 0 otherwise
    genvar gi;
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_src
            if (gi < N_SRC) begin : g_on
                irq_sync #(
                    .SYNC_STAGES(SYNC_STAGES)
                ) u_sync (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .irq_i  (irq[gi]),
                    .level_o(level_w[gi]),
                    .edge_o (rise_w[gi])
                );
            end else begin : g_off
                assign level_w[gi] = 1'b0;
                assign rise_w[gi]  = 1'b0;
            end
        end
    endgenerate

    // Upper write-data bits have no backing storage
    assign unused_w = &{1'b0, reg_wdata[15:8]};

    // Edge-mode bits come from the latch, level-mode bits follow the synced input
    assign pending_w  = (mode_q & pend_q) | (~mode_q & level_w);
    assign cand_w     = pending_w & mask_q;
    assign winner_w   = lowest_idx(cand_w);
    assign isr_low_w  = lowest_idx(isr_q);
    assign win_oh_w   = 8'd1 << winner_w;
    // Only strictly higher priority than the current in-service level may nest
    assign eligible_w = (cand_w != 8'd0) && ((isr_q == 8'd0) || (winner_w < isr_low_w));
    assign ack_hit_w  = intack & eligible_w;
    assign wr_w       = reg_sel & reg_we;

    // Next-state for the register file, pending latch and in-service set
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        pend_d = pend_q;
        isr_d  = isr_q;

        if (wr_w && reg_addr == REG_MASK) mask_d = reg_wdata[7:0] & SRC_MASK;
        if (wr_w && reg_addr == REG_MODE) mode_d = reg_wdata[7:0] & SRC_MASK;

        // Clears first, then a new edge in the same cycle wins
        if (wr_w && reg_addr == REG_PEND) pend_d = pend_d & ~reg_wdata[7:0];
        if (ack_hit_w)                    pend_d = pend_d & ~win_oh_w;
        pend_d = (pend_d | rise_w) & mode_q;

        // EOI retires the highest-priority in-service bit before the ack sets its own
        if (wr_w && reg_addr == REG_ISR) isr_d = isr_d & ~lowest_onehot(isr_q);
        if (ack_hit_w)                   isr_d = isr_d | win_oh_w;
    end

    // Register file, pending latch and in-service set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 8'h00;
            mode_q <= SRC_MASK;
            pend_q <= 8'h00;
            isr_q  <= 8'h00;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            isr_q  <= isr_d;
        end
    end

    // INT handshake FSM with registered request output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
        end else if (intack) begin
            state_q <= ST_ACKED;
            intr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eligible_w) begin
                        state_q <= ST_ARMED;
                        intr_q  <= 1'b1;
                    end else begin
                        intr_q  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (!eligible_w) begin
                        state_q <= ST_IDLE;
                        intr_q  <= 1'b0;
                    end else begin
                        intr_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr = intr_q;

    // Vector is only driven during the acknowledge window and never in reset
    always_comb begin
        vec_out = 16'h0000;
        if (intack && rst_n) begin
            vec_out = eligible_w ? 16'(winner_w) : 16'(SPURIOUS_VEC);
        end
    end

    // Combinational register read port
    always_comb begin
        reg_rdata = 16'h0000;
        case (reg_addr)
            REG_MASK: reg_rdata = {8'h00, mask_q};
            REG_PEND: reg_rdata = {8'h00, pending_w};
            REG_MODE: reg_rdata = {8'h00, mode_q};
            default:  reg_rdata = {8'h00, isr_q};
        endcase
    end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Self-checking bench for vec_int_ctrl: directed scenarios followed by
// randomized multi-source bursts checked against a transaction-level model.
module tb_vec_int_ctrl;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_MODE = 2'd2;
    localparam logic [1:0] A_ISR  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq;
    logic        reg_sel;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        intr;
    logic        intack;
    logic [15:0] vec_out;

    int checks = 0;
    int errors = 0;

    vec_int_ctrl #(
        .N_SRC(8),
        .SYNC_STAGES(2),
        .SPURIOUS_VEC(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .reg_sel  (reg_sel),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .intr     (intr),
        .intack   (intack),
        .vec_out  (vec_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%04h expected=0x%04h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_sel   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        cyc(1);
        reg_sel   = 1'b0;
        reg_we    = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        reg_addr = a;
        #1;
        chk(tag, reg_rdata, exp);
    endtask

    // Present intack for one cycle and capture the vector it returns
    task automatic ack(output logic [15:0] v);
        intack = 1'b1;
        #1;
        v = vec_out;
        cyc(1);
        intack = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq = bits;
        cyc(1);
        irq = 8'h00;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Hard bound on total runtime
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  mask, set, exp_pend, exp_isr, cand;
        int          w;

        rst_n = 1'b0; irq = 8'h00; reg_sel = 1'b0; reg_we = 1'b0;
        reg_addr = 2'd0; reg_wdata = 16'h0; intack = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Reset state
        chk("rst_intr", {15'h0, intr}, 16'h0);
        chk("rst_vec", vec_out, 16'h0);
        chk_reg("rst_mask", A_MASK, 16'h0000);
        chk_reg("rst_pend", A_PEND, 16'h0000);
        chk_reg("rst_mode", A_MODE, 16'h00FF);
        chk_reg("rst_isr", A_ISR, 16'h0000);

        // Basic request/ack with latency
        wr(A_MASK, 16'h0005);
        pulse(8'h04);
        cyc(1);
        chk_reg("t1_pend_early", A_PEND, 16'h0000);
        cyc(1);
        chk_reg("t1_pend", A_PEND, 16'h0004);
        chk("t1_intr_early", {15'h0, intr}, 16'h0);
        cyc(1);
        chk("t1_intr", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t1_vec", v, 16'h0002);
        chk_reg("t1_isr", A_ISR, 16'h0004);
        chk_reg("t1_pend_clr", A_PEND, 16'h0000);
        chk("t1_intr_drop", {15'h0, intr}, 16'h0);
        wr(A_ISR, 16'h0000);
        chk_reg("t1_eoi", A_ISR, 16'h0000);

        // Simultaneous edges: priority order
        wr(A_MASK, 16'h00FF);
        pulse(8'h05);
        cyc(3);
        chk("t2_intr", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t2_vec0", v, 16'h0000);
        cyc(2);
        chk("t2_blocked", {15'h0, intr}, 16'h0);
        wr(A_ISR, 16'h0000);
        chk_reg("t2_eoi", A_ISR, 16'h0000);
        cyc(1);
        chk("t2_intr2", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t2_vec2", v, 16'h0002);
        wr(A_ISR, 16'h0000);

        // Nesting: only strictly higher priority preempts
        pulse(8'h04);
        cyc(3);
        ack(v);
        chk("t3_vec2", v, 16'h0002);
        pulse(8'h20);
        cyc(3);
        chk_reg("t3_pend5", A_PEND, 16'h0020);
        chk("t3_no_nest", {15'h0, intr}, 16'h0);
        pulse(8'h02);
        cyc(3);
        chk("t3_nest_intr", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t3_vec1", v, 16'h0001);
        chk_reg("t3_isr6", A_ISR, 16'h0006);
        wr(A_ISR, 16'h0000);
        chk_reg("t3_isr4", A_ISR, 16'h0004);
        cyc(1);
        chk("t3_still_blk", {15'h0, intr}, 16'h0);
        wr(A_ISR, 16'h0000);
        cyc(1);
        chk("t3_intr5", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t3_vec5", v, 16'h0005);
        wr(A_ISR, 16'h0000);

        // Spurious acknowledge after the source is masked away
        wr(A_MASK, 16'h0008);
        pulse(8'h08);
        cyc(3);
        chk("t4_intr", {15'h0, intr}, 16'h1);
        wr(A_MASK, 16'h0000);
        chk("t4_intr_held", {15'h0, intr}, 16'h1);
        ack(v);
        chk("t4_vec_spur", v, 16'h0008);
        chk_reg("t4_isr", A_ISR, 16'h0000);
        chk_reg("t4_pend", A_PEND, 16'h0008);
        wr(A_PEND, 16'h0008);
        chk_reg("t4_w1c", A_PEND, 16'h0000);

        // Level mode
        wr(A_MODE, 16'h00FE);
        wr(A_MASK, 16'h0001);
        irq = 8'h01;
        cyc(2);
        chk_reg("t5_pend_lvl", A_PEND, 16'h0001);
        wr(A_PEND, 16'h0001);
        chk_reg("t5_w1c_noeff", A_PEND, 16'h0001);
        chk("t5_intr", {15'h0, intr}, 16'h1);
        irq = 8'h00;
        cyc(2);
        chk_reg("t5_pend_drop", A_PEND, 16'h0000);
        cyc(1);
        chk("t5_intr_drop", {15'h0, intr}, 16'h0);
        wr(A_MODE, 16'h00FF);

        // Randomized bursts against a transaction-level model
        for (int it = 0; it < 16; it++) begin
            mask = 8'($urandom_range(0, 255));
            set  = 8'($urandom_range(1, 255));
            wr(A_MASK, {8'h00, mask});
            pulse(set);
            cyc(2);
            chk_reg("rnd_pend", A_PEND, {8'h00, set});
            cyc(1);
            cand = set & mask;
            chk("rnd_intr", {15'h0, intr}, {15'h0, (cand != 8'h00)});
            exp_pend = set;
            while ((exp_pend & mask) != 8'h00) begin
                w = lowest(exp_pend & mask);
                ack(v);
                chk("rnd_vec", v, 16'(w));
                exp_pend = exp_pend & ~(8'd1 << w);
                exp_isr  = 8'd1 << w;
                chk_reg("rnd_isr", A_ISR, {8'h00, exp_isr});
                chk_reg("rnd_pend_ack", A_PEND, {8'h00, exp_pend});
                chk("rnd_intr_ack", {15'h0, intr}, 16'h0);
                wr(A_ISR, 16'h0000);
                chk_reg("rnd_eoi", A_ISR, 16'h0000);
                cyc(1);
                chk("rnd_intr_nxt", {15'h0, intr}, {15'h0, ((exp_pend & mask) != 8'h00)});
            end
            wr(A_PEND, 16'h00FF);
            chk_reg("rnd_w1c", A_PEND, 16'h0000);
        end

        // Asynchronous reset while armed
        wr(A_MASK, 16'h00FF);
        pulse(8'h10);
        cyc(2);
        chk_reg("t6_pend", A_PEND, 16'h0010);
        cyc(1);
        chk("t6_intr", {15'h0, intr}, 16'h1);
        #2;
        rst_n  = 1'b0;
        intack = 1'b1;
        #1;
        chk("t6_intr_rst", {15'h0, intr}, 16'h0);
        chk("t6_vec_rst", vec_out, 16'h0000);
        chk_reg("t6_mask", A_MASK, 16'h0000);
        chk_reg("t6_pend_rst", A_PEND, 16'h0000);
        chk_reg("t6_mode", A_MODE, 16'h00FF);
        chk_reg("t6_isr", A_ISR, 16'h0000);
        intack = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("t6_intr_post", {15'h0, intr}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
